// File: rtl/sram_march_bist.sv
// March C- built-in self test for a single-port SRAM macro: drives one registered
// operation per cycle and checks read data returning one cycle after each read.
module sram_march_bist #(
  parameter int                      P_ADDR_WIDTH = 8,
  parameter int                      P_DATA_WIDTH = 64,
  parameter logic [P_DATA_WIDTH-1:0] P_BG         = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic [11:0]             FAIL_CNT,
  output logic                    BIST_EN,
  output logic                    BIST_MEN,
  output logic                    BIST_WEN,
  output logic                    BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] DOUT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam logic [P_ADDR_WIDTH-1:0] LP_AMAX = '1;

  function automatic logic f_down(input logic [2:0] elem);
    return (elem == 3'd3) || (elem == 3'd4);
  endfunction

  function automatic logic [P_ADDR_WIDTH-1:0] f_first(input logic [2:0] elem);
    return f_down(elem) ? LP_AMAX : '0;
  endfunction

  function automatic logic [P_ADDR_WIDTH-1:0] f_last(input logic [2:0] elem);
    return f_down(elem) ? '0 : LP_AMAX;
  endfunction

  // E1/E3 write "1"; E0/E2/E4 write "0".
  function automatic logic [P_DATA_WIDTH-1:0] f_wpat(input logic [2:0] elem);
    return ((elem == 3'd1) || (elem == 3'd3)) ? ~P_BG : P_BG;
  endfunction

  // E2/E4 expect "1"; E1/E3/E5 expect "0".
  function automatic logic [P_DATA_WIDTH-1:0] f_rpat(input logic [2:0] elem);
    return ((elem == 3'd2) || (elem == 3'd4)) ? ~P_BG : P_BG;
  endfunction

  state_t                    r_state;
  logic [2:0]                r_elem;
  logic [P_ADDR_WIDTH-1:0]   r_addr;
  logic                      r_wr;
  logic                      r_en, r_men, r_wen, r_ren;
  logic [P_ADDR_WIDTH-1:0]   r_bist_addr;
  logic [P_DATA_WIDTH-1:0]   r_din, r_bm;
  logic                      r_vld_p0, r_vld_p1;
  logic [P_DATA_WIDTH-1:0]   r_exp_p0, r_exp_p1;
  logic [P_ADDR_WIDTH-1:0]   r_taddr_p0, r_taddr_p1;
  logic [2:0]                r_telem_p0, r_telem_p1;
  logic                      r_fail;
  logic [P_ADDR_WIDTH-1:0]   r_fail_addr;
  logic [2:0]                r_fail_elem;
  logic [11:0]               r_fail_cnt;

  state_t                    w_state_nxt;
  logic [2:0]                w_elem_nxt;
  logic [P_ADDR_WIDTH-1:0]   w_addr_nxt;
  logic                      w_wr_nxt;
  logic                      w_op_nxt;
  logic                      w_en_nxt;
  logic                      w_start_acc;
  logic                      w_mis;

  assign w_start_acc = (r_state == S_IDLE) && START;
  assign w_mis       = r_vld_p1 && (DOUT != r_exp_p1);

  // r_elem/r_addr/r_wr describe the operation currently on the macro pins.
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_wr_nxt    = r_wr;
    w_op_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_RUN;
          w_elem_nxt  = 3'd0;
          w_addr_nxt  = '0;
          w_wr_nxt    = 1'b1;
          w_op_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if ((r_elem inside {[3'd1:3'd4]}) && !r_wr) begin
          w_wr_nxt = 1'b1;
          w_op_nxt = 1'b1;
        end else if (r_addr == f_last(r_elem)) begin
          if (r_elem == 3'd5) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_elem_nxt = r_elem + 3'd1;
            w_addr_nxt = f_first(r_elem + 3'd1);
            w_wr_nxt   = 1'b0;
            w_op_nxt   = 1'b1;
          end
        end else begin
          w_addr_nxt = f_down(r_elem) ? r_addr - 1'b1 : r_addr + 1'b1;
          w_wr_nxt   = (r_elem == 3'd0);
          w_op_nxt   = 1'b1;
        end
      end
      S_DRAIN: w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_en_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_elem      <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_en        <= 1'b0;
      r_men       <= 1'b0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_bist_addr <= '0;
      r_din       <= '0;
      r_bm        <= '0;
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_elem      <= w_elem_nxt;
      r_addr      <= w_addr_nxt;
      r_wr        <= w_wr_nxt;
      r_en        <= w_en_nxt;
      r_bm        <= {P_DATA_WIDTH{w_en_nxt}};
      r_men       <= w_op_nxt;
      r_wen       <= w_op_nxt && w_wr_nxt;
      r_ren       <= w_op_nxt && !w_wr_nxt;
      r_bist_addr <= w_op_nxt ? w_addr_nxt : '0;
      r_din       <= (w_op_nxt && w_wr_nxt) ? f_wpat(w_elem_nxt) : '0;
      // p0: read issued to macro; p1: macro access edge; compare on DOUT next edge
      r_vld_p0    <= w_op_nxt && !w_wr_nxt;
      r_vld_p1    <= r_vld_p0;
      if (w_start_acc) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= '0;
        r_fail_cnt  <= '0;
      end else if (w_mis) begin
        r_fail <= 1'b1;
        if (r_fail_cnt != 12'hFFF) r_fail_cnt <= r_fail_cnt + 12'd1;
        if (!r_fail) begin
          r_fail_addr <= r_taddr_p1;
          r_fail_elem <= r_telem_p1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    r_exp_p0   <= f_rpat(w_elem_nxt);
    r_taddr_p0 <= w_addr_nxt;
    r_telem_p0 <= w_elem_nxt;
    r_exp_p1   <= r_exp_p0;
    r_taddr_p1 <= r_taddr_p0;
    r_telem_p1 <= r_telem_p0;
  end

  assign BUSY      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign DONE      = (r_state == S_FIN);
  assign FAIL      = r_fail;
  assign FAIL_ADDR = r_fail_addr;
  assign FAIL_ELEM = r_fail_elem;
  assign FAIL_CNT  = r_fail_cnt;
  assign BIST_EN   = r_en;
  assign BIST_MEN  = r_men;
  assign BIST_WEN  = r_wen;
  assign BIST_REN  = r_ren;
  assign BIST_ADDR = r_bist_addr;
  assign BIST_DIN  = r_din;
  assign BIST_BM   = r_bm;

endmodule
